stage2_mixer: RTL and testbench
===============================

Name: stage2_mixer

Overview:
- Downstream neighbour of stage1. Consumes stg1_out each time stage1 raises its done flag.
- Holds the key bits that were sampled at capture and runs ROUNDS cycles of keyed rotate/XOR mixing on the 16-bit word.
- Presents the result on stg2_out with a valid/ready handshake toward stage3.
- Flags any stage1 result that arrives while it is busy.

Parameters:
- ROUNDS, 4: number of mixing rounds, legal range 1..255; round index r is 8 bits.
- WIDTH, 16: datapath width; only 16 is supported, and RC packing assumes 16.

Ports:
- clk1  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- key_bits  in  5  key shared with stage1; bits [1:0] and [4:0] are used here.
- stg1_out  in  16  stage1 result word.
- stg1_done  in  1  stage1 done flag; level, registered in the clk1 domain.
- out_ready  in  1  downstream ready.
- stg2_out  out  16  mixed result; stable while stg2_valid=1.
- stg2_valid  out  1  result available.
- busy  out  1  high in RUN or HOLD.
- overrun  out  1  sticky; a stage1 result was dropped.
- clr_overrun  in  1  synchronous clear of overrun.

Behaviour:
- Reset, asynchronous: state=IDLE, stg2_out=0, stg2_valid=0, busy=0, overrun=0, done_q=0, data_q=0, key_q=0, round=0.
- Event detection: done_q registers stg1_done every cycle. A capture event is stg1_done=1 && done_q=0 (rising edge). A level held high is not a new event.
- If stg1_done is already high at the first edge after reset, that counts as an event.
- Round function, with d = data_q, k = key_q:
  - d_next = rotl16(d, 1 + k[1:0]) XOR RC(r).
  - RC(r) = {k[4:0], 3'b000, r[7:0]}.
  - Rotate amount is 1..4. There is no carry and no widening.
- FSM:
  - IDLE: on an event, data_q<=stg1_out, key_q<=key_bits, round<=0, go to RUN. Otherwise hold.
  - RUN: each cycle, data_q<=round function, round<=round+1. On the cycle that processes round==ROUNDS-1: stg2_out<=result, stg2_valid<=1, go to HOLD.
  - HOLD: stg2_valid=1, stg2_out held. When out_ready=1: stg2_valid<=0 and go to IDLE. If an event occurs on that same cycle, capture it and go directly to RUN (back-to-back, no bubble).
- Latency: event sampled at edge N (capture). Rounds occur at edges N+1..N+ROUNDS. stg2_valid is high after edge N+ROUNDS.
- Key changes on key_bits after capture do not affect the current word.
- Overrun: an event in RUN, or in HOLD with out_ready=0, drops that input and sets overrun<=1. overrun stays set until clr_overrun=1.
  - If clr_overrun and a new overrun event occur on the same cycle, set wins.
- busy = (state != IDLE); combinational from the state register.
- stg2_out keeps its last value after the handshake until it is overwritten by the next completion.
- out_ready is ignored outside HOLD.
- Reset asserted mid-RUN or mid-HOLD aborts the operation immediately. No stg2_valid pulse follows.

Decomposition:
- Shared package stage_pkg holds:
  - state enum {IDLE, RUN, HOLD};
  - WIDTH localparam;
  - the function rc(key, r);
  - the function rotl16(d, amt).
- Sub-module stage2_round: purely combinational (d, key, r) -> d_next. It is reused by the bench's reference model.

Test Plan:
- ROUNDS=4, key_bits=5'b00000, stg1_out=0x0001, rising stg1_done, out_ready=1 -> stg2_valid rises 4 edges after capture with stg2_out=0x0013, and drops the next edge.
- key_bits=5'b00011, stg1_out=0x0000 -> intermediates 0x1800, 0x9800, 0x980B, then stg2_out=0x98BA.
- out_ready=0 for 10 cycles after completion -> stg2_valid stays 1 and stg2_out is stable at 0x0013. Raising out_ready then drops valid at the next edge.
- Second stg1_done rise during RUN -> input dropped, overrun=1, first result still 0x0013. clr_overrun pulse -> overrun=0.
- In HOLD, out_ready=1 on the same cycle as a new rise with stg1_out=0x0001, key 0 -> immediate RUN, a second 0x0013 result after 4 edges, overrun=0.
- Assert rst mid-RUN (round 2) -> all outputs 0 asynchronously. After release with stg1_done=0, no valid pulse. stg1_done held high with no edge -> no capture.

Source files
------------

// File: rtl/stage_pkg.sv
// Definitions shared by the stage pipeline: FSM states, datapath width and the
// keyed mixing primitives.
package stage_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Round constant: key in the top five bits, round index in the low byte.
    function automatic logic [15:0] rc(input logic [4:0] key, input logic [7:0] r);
        return {key, 3'b000, r};
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] d, input logic [2:0] amt);
        logic [31:0] t;
        t = {d, d} << amt;
        return t[31:16];
    endfunction

endpackage

// File: rtl/stage2_round.sv
// One keyed mixing round: rotate left by 1..4 (from key[1:0]) and XOR the
// round constant.
module stage2_round
    import stage_pkg::*;
(
    input  logic [WIDTH-1:0] d,
    input  logic [4:0]       key,
    input  logic [7:0]       r,
    output logic [WIDTH-1:0] d_next
);

    logic [2:0] amt;

    assign amt    = {1'b0, key[1:0]} + 3'd1;
    assign d_next = rotl16(d, amt) ^ rc(key, r);

endmodule

// File: rtl/stage2_mixer.sv
// Second pipeline stage: captures each stage1 result on the rising edge of its
// done flag, mixes it for ROUNDS cycles and offers it to stage3 via valid/ready.
module stage2_mixer #(
    parameter int ROUNDS = 4,
    parameter int WIDTH  = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic [4:0]       key_bits,
    input  logic [WIDTH-1:0] stg1_out,
    input  logic             stg1_done,
    input  logic             out_ready,
    input  logic             clr_overrun,
    output logic [WIDTH-1:0] stg2_out,
    output logic             stg2_valid,
    output logic             busy,
    output logic             overrun
);
    import stage_pkg::*;

    localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);

    state_t           state, state_nx;
    logic             done_q;
    logic [WIDTH-1:0] data_q;
    logic [4:0]       key_q;
    logic [7:0]       round;
    logic [WIDTH-1:0] d_next;

    logic event_w, capture, finish, release_w, drop;

    assign event_w = stg1_done & ~done_q;
    assign busy    = (state != IDLE);

    stage2_round u_round (
        .d      (data_q),
        .key    (key_q),
        .r      (round),
        .d_next (d_next)
    );

    always_comb begin
        state_nx  = state;
        capture   = 1'b0;
        finish    = 1'b0;
        release_w = 1'b0;
        drop      = 1'b0;
        case (state)
            IDLE: begin
                if (event_w) begin
                    capture  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                drop = event_w;
                if (round == LAST_ROUND) begin
                    finish   = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                // A handshake frees the stage in the same cycle, so a coincident
                // new result is taken without a bubble.
                if (out_ready) begin
                    release_w = 1'b1;
                    state_nx  = IDLE;
                    if (event_w) begin
                        capture  = 1'b1;
                        state_nx = RUN;
                    end
                end else begin
                    drop = event_w;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            data_q     <= '0;
            key_q      <= '0;
            round      <= '0;
            stg2_out   <= '0;
            stg2_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= stg1_done;

            if (capture) begin
                data_q <= stg1_out;
                key_q  <= key_bits;
                round  <= '0;
            end else if (state == RUN) begin
                data_q <= d_next;
                round  <= round + 8'd1;
            end

            if (finish) begin
                stg2_out   <= d_next;
                stg2_valid <= 1'b1;
            end else if (release_w) begin
                stg2_valid <= 1'b0;
            end

            // Set has priority over a coincident clear.
            if (drop)
                overrun <= 1'b1;
            else if (clr_overrun)
                overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stage2_mixer.sv
// Bench for stage2_mixer: reference model computes each result in one step at
// capture and tracks when it must appear; directed scenarios add literal checks.
module tb_stage2_mixer;

    localparam int ROUNDS = 4;

    logic        clk1 = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  key_bits = '0;
    logic [15:0] stg1_out = '0;
    logic        stg1_done = 1'b0;
    logic        out_ready = 1'b1;
    logic        clr_overrun = 1'b0;
    logic [15:0] stg2_out;
    logic        stg2_valid;
    logic        busy;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    stage2_mixer #(.ROUNDS(ROUNDS), .WIDTH(16)) dut (
        .clk1        (clk1),
        .rst         (rst),
        .key_bits    (key_bits),
        .stg1_out    (stg1_out),
        .stg1_done   (stg1_done),
        .out_ready   (out_ready),
        .clr_overrun (clr_overrun),
        .stg2_out    (stg2_out),
        .stg2_valid  (stg2_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk1 = ~clk1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // n rounds of the keyed mixing applied to d.
    function automatic logic [15:0] mix(input logic [15:0] d, input logic [4:0] k, input int n);
        logic [15:0] x;
        int a;
        x = d;
        a = int'(k[1:0]) + 1;
        for (int r = 0; r < n; r++)
            x = ((x << a) | (x >> (16 - a))) ^ {k, 3'b000, 8'(r)};
        return x;
    endfunction

    // Reference model: result known at capture, published ROUNDS edges later.
    logic        m_prev = 1'b0;
    int          m_left = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_out = '0;
    logic [15:0] m_res = '0;
    logic        m_ovr = 1'b0;

    always @(posedge clk1 or posedge rst) begin
        logic ev, start, dropped;
        if (rst) begin
            m_prev = 1'b0; m_left = 0; m_valid = 1'b0;
            m_out = '0; m_res = '0; m_ovr = 1'b0;
        end else begin
            ev = stg1_done && !m_prev;
            m_prev = stg1_done;
            start = 1'b0;
            dropped = 1'b0;
            if (m_left > 0) begin
                dropped = ev;
                m_left--;
                if (m_left == 0) begin
                    m_valid = 1'b1;
                    m_out = m_res;
                end
            end else if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    start = ev;
                end else begin
                    dropped = ev;
                end
            end else begin
                start = ev;
            end
            if (start) begin
                m_res = mix(stg1_out, key_bits, ROUNDS);
                m_left = ROUNDS;
            end
            if (dropped) m_ovr = 1'b1;
            else if (clr_overrun) m_ovr = 1'b0;
        end
    end

    always @(negedge clk1) begin
        check("valid", 32'(stg2_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_left > 0 || m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("out", 32'(stg2_out), 32'(m_out));
    end

    task automatic tick();
        @(posedge clk1);
        #3;
    endtask

    initial begin
        #1 rst = 1'b1;
        #11 rst = 1'b0;

        // Pin the model against hand-computed values.
        check("model_k0", 32'(mix(16'h0001, 5'b00000, 4)), 32'h0013);
        check("model_k3_r1", 32'(mix(16'h0000, 5'b00011, 1)), 32'h1800);
        check("model_k3_r2", 32'(mix(16'h0000, 5'b00011, 2)), 32'h9800);
        check("model_k3_r3", 32'(mix(16'h0000, 5'b00011, 3)), 32'h980B);
        check("model_k3_r4", 32'(mix(16'h0000, 5'b00011, 4)), 32'h98BA);
        check("reset_out", 32'(stg2_out), 32'h0);
        check("reset_valid", 32'(stg2_valid), 32'h0);

        // Basic run, done held high afterwards must not retrigger.
        stg1_out = 16'h0001; key_bits = 5'b00000; stg1_done = 1'b1;
        tick();
        repeat (3) tick();
        check("t1_not_yet", 32'(stg2_valid), 32'h0);
        tick();
        check("t1_valid", 32'(stg2_valid), 32'h1);
        check("t1_out", 32'(stg2_out), 32'h0013);
        tick();
        check("t1_drop", 32'(stg2_valid), 32'h0);
        check("t1_out_kept", 32'(stg2_out), 32'h0013);
        repeat (5) begin
            tick();
            check("t1_level_no_capture", 32'(busy), 32'h0);
        end
        stg1_done = 1'b0;
        tick();

        // Keyed run with intermediates; key change after capture is ignored.
        stg1_out = 16'h0000; key_bits = 5'b00011; stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0; key_bits = 5'b11111;
        check("t2_cap", 32'(dut.data_q), 32'h0000);
        tick(); check("t2_r0", 32'(dut.data_q), 32'h1800);
        tick(); check("t2_r1", 32'(dut.data_q), 32'h9800);
        tick(); check("t2_r2", 32'(dut.data_q), 32'h980B);
        tick(); check("t2_out", 32'(stg2_out), 32'h98BA);
        tick();

        // Backpressure: result held stable.
        out_ready = 1'b0; stg1_out = 16'h0001; key_bits = 5'b00000; stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0;
        repeat (ROUNDS) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t3_hold_valid", 32'(stg2_valid), 32'h1);
            check("t3_hold_out", 32'(stg2_out), 32'h0013);
        end
        out_ready = 1'b1;
        tick();
        check("t3_release", 32'(stg2_valid), 32'h0);

        // Overrun during RUN, then clear.
        stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0;
        tick();
        stg1_done = 1'b1; stg1_out = 16'hFFFF;
        tick();
        check("t4_overrun_set", 32'(overrun), 32'h1);
        stg1_done = 1'b0; stg1_out = 16'h0001;
        repeat (2) tick();
        check("t4_first_result", 32'(stg2_out), 32'h0013);
        tick();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("t4_overrun_clr", 32'(overrun), 32'h0);

        // Back-to-back: release and capture on the same edge.
        out_ready = 1'b0; stg1_out = 16'h0000; key_bits = 5'b00011; stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0;
        repeat (ROUNDS) tick();
        check("t5_first", 32'(stg2_out), 32'h98BA);
        tick();
        out_ready = 1'b1; stg1_out = 16'h0001; key_bits = 5'b00000; stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0;
        check("t5_b2b_valid", 32'(stg2_valid), 32'h0);
        check("t5_b2b_busy", 32'(busy), 32'h1);
        repeat (ROUNDS) tick();
        check("t5_second", 32'(stg2_out), 32'h0013);
        check("t5_no_overrun", 32'(overrun), 32'h0);
        tick();

        // Asynchronous reset at round 2.
        stg1_done = 1'b1;
        tick();
        stg1_done = 1'b0;
        repeat (2) tick();
        #1 rst = 1'b1;
        #1;
        check("t6_rst_out", 32'(stg2_out), 32'h0);
        check("t6_rst_valid", 32'(stg2_valid), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        tick();
        rst = 1'b0;
        repeat (6) begin
            tick();
            check("t6_no_pulse", 32'(stg2_valid), 32'h0);
        end

        // Done already high at the first edge after reset counts as an event.
        rst = 1'b1;
        stg1_done = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("t7_capture", 32'(busy), 32'h1);
        repeat (ROUNDS) tick();
        check("t7_out", 32'(stg2_out), 32'h0013);
        repeat (3) tick();
        stg1_done = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
